sprite_mem_arbiter: RTL and testbench

- Shares the single-port sprite memory between two requesters: the pixel print path (read address every pixel tick) and the processor write path (sprite pixel uploads).
- Processor writes are buffered in a small FIFO. They drain only when the print path does not need the port, so uploads never corrupt the scanout.
- Sits between the sprite print module's address output, the bus write interface, and the sprite memory port.

---
 rtl/sprite_mem_arbiter.sv | 157 +++++++++++++++
 tb/tb_sprite_mem_arbiter.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_mem_arbiter.sv
// Sprite memory port arbiter.
// Shares the single-port sprite memory between the pixel print path (reads)
// and buffered processor uploads (writes). Uploads wait in a small FIFO and
// drain only while the print path leaves the port idle.
// Optional build macro: SPRITE_ARB_STARVE_EN adds a starvation counter that
// forces one queued write through after starve_limit blocked pixel ticks.
module sprite_mem_arbiter #(
   parameter int size_address    = 14,
   parameter int data_bits       = 9,
   parameter int fifo_depth_log2 = 2,
   parameter int starve_limit    = 64
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    pixel_tick,
   input  logic                    print_busy,
   input  logic [size_address-1:0] print_address,
   input  logic                    wr_req,
   input  logic [size_address-1:0] wr_address,
   input  logic [data_bits-1:0]    wr_data,
   output logic                    wr_ack,
   output logic                    fifo_full,
   output logic [size_address-1:0] mem_address,
   output logic [data_bits-1:0]    mem_data,
   output logic                    mem_wren,
   output logic                    print_stall
);

   localparam int fifo_depth = 1 << fifo_depth_log2;
   localparam int pw         = fifo_depth_log2 + 1;

   localparam logic [0:0] S_PRINT = 1'b0;
   localparam logic [0:0] S_DRAIN = 1'b1;

   logic [0:0]              state;
   logic [0:0]              state_next;
   logic [pw-1:0]           wr_ptr;
   logic [pw-1:0]           rd_ptr;
   logic [pw-1:0]           wr_ptr_next;
   logic [pw-1:0]           rd_ptr_next;
   logic [pw-1:0]           fill;
   logic [size_address-1:0] addr_store [fifo_depth];
   logic [data_bits-1:0]    data_store [fifo_depth];
   logic                    fifo_empty;
   logic                    drain_pop;
   logic                    force_pop;
   logic                    pop;
   logic                    push;

   // Extra MSB on the pointers tells full from empty; fill can only reach
   // fifo_depth, so its MSB alone flags a full FIFO.
   assign fill       = wr_ptr - rd_ptr;
   assign fifo_full  = fill[pw-1];
   assign fifo_empty = (wr_ptr == rd_ptr);

   // A normal drain write only happens while the print path is idle.
   assign drain_pop  = (state == S_DRAIN) && !fifo_empty && !print_busy;
   assign pop        = drain_pop || force_pop;

   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push        = wr_req && (!fifo_full || pop);
   assign wr_ptr_next = wr_ptr + pw'(push);
   assign rd_ptr_next = rd_ptr + pw'(pop);

`ifdef SPRITE_ARB_STARVE_EN
   localparam int cw = $clog2(starve_limit + 1);

   logic [cw-1:0] starve_cnt;

   assign force_pop = (starve_cnt == cw'(starve_limit)) && !fifo_empty;

   // Count pixel ticks on which a queued write is held off by the print path.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_cnt <= '0;
      end else if (fifo_empty || pop) begin
         starve_cnt <= '0;
      end else if (pixel_tick && print_busy && (starve_cnt != cw'(starve_limit))) begin
         starve_cnt <= starve_cnt + cw'(1);
      end
   end

   // Flag the cycle in which a forced write displaced the print read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         print_stall <= 1'b0;
      end else begin
         print_stall <= force_pop;
      end
   end
`else
   logic unused_tick;
   localparam int unused_starve_limit = starve_limit;

   assign unused_tick = pixel_tick;
   assign force_pop   = 1'b0;
   assign print_stall = 1'b0;
`endif

   // Decide whether the port belongs to the print path or to queued writes.
   always_comb begin
      state_next = state;
      case (state)
         S_PRINT: begin
            if (!print_busy && !fifo_empty) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (print_busy || (wr_ptr_next == rd_ptr_next)) begin
               state_next = S_PRINT;
            end
         end
         default: state_next = S_PRINT;
      endcase
   end

   // State, FIFO pointers and the accept pulse back to the processor.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_PRINT;
         wr_ptr <= '0;
         rd_ptr <= '0;
         wr_ack <= 1'b0;
      end else begin
         state  <= state_next;
         wr_ptr <= wr_ptr_next;
         rd_ptr <= rd_ptr_next;
         wr_ack <= push;
      end
   end

   // FIFO storage needs no reset; only entries between the pointers are read.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_store[wr_ptr[pw-2:0]] <= wr_address;
         data_store[wr_ptr[pw-2:0]] <= wr_data;
      end
   end

   // Register the memory port: the FIFO head when writing, else the print read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mem_address <= '0;
         mem_data    <= '0;
         mem_wren    <= 1'b0;
      end else if (pop) begin
         mem_address <= addr_store[rd_ptr[pw-2:0]];
         mem_data    <= data_store[rd_ptr[pw-2:0]];
         mem_wren    <= 1'b1;
      end else begin
         mem_address <= print_address;
         mem_wren    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Directed testbench for sprite_mem_arbiter.
// Inputs change 1 ns after each rising edge; outputs are checked at that point.
module tb_sprite_mem_arbiter;

   logic        clk;
   logic        reset;
   logic        pixel_tick;
   logic        print_busy;
   logic [13:0] print_address;
   logic        wr_req;
   logic [13:0] wr_address;
   logic [8:0]  wr_data;
   logic        wr_ack;
   logic        fifo_full;
   logic [13:0] mem_address;
   logic [8:0]  mem_data;
   logic        mem_wren;
   logic        print_stall;

   int compared;
   int mismatched;

   sprite_mem_arbiter #(
      .size_address   (14),
      .data_bits      (9),
      .fifo_depth_log2(2),
      .starve_limit   (4)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pixel_tick   (pixel_tick),
      .print_busy   (print_busy),
      .print_address(print_address),
      .wr_req       (wr_req),
      .wr_address   (wr_address),
      .wr_data      (wr_data),
      .wr_ack       (wr_ack),
      .fifo_full    (fifo_full),
      .mem_address  (mem_address),
      .mem_data     (mem_data),
      .mem_wren     (mem_wren),
      .print_stall  (print_stall)
   );

   // Free-running 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic apply_stimulus(input logic req, input logic [13:0] addr,
                                 input logic [8:0] data);
      wr_req     = req;
      wr_address = addr;
      wr_data    = data;
   endtask

   // Directed sequence covering reset, idle writes, blocking and draining.
   initial begin
      compared      = 0;
      mismatched    = 0;
      reset         = 1'b0;
      pixel_tick    = 1'b0;
      print_busy    = 1'($urandom);
      print_address = 14'($urandom);
      apply_stimulus(1'b1, 14'($urandom), 9'($urandom));

      // Reset held with active inputs
      step();
      step();
      step();
      check_output("rst_wren", 32'(mem_wren), 32'd0);
      check_output("rst_addr", 32'(mem_address), 32'd0);
      check_output("rst_data", 32'(mem_data), 32'd0);
      check_output("rst_ack", 32'(wr_ack), 32'd0);
      check_output("rst_full", 32'(fifo_full), 32'd0);
      check_output("rst_stall", 32'(print_stall), 32'd0);

      apply_stimulus(1'b0, 14'h0, 9'h0);
      print_busy    = 1'b1;
      print_address = 14'h1234;
      #2;
      reset = 1'b1;
      step();
      check_output("follow_addr", 32'(mem_address), 32'h1234);
      check_output("follow_wren", 32'(mem_wren), 32'd0);

      // Idle write
      $display("[TB] idle write");
      print_busy = 1'b0;
      apply_stimulus(1'b1, 14'h0042, 9'h1FF);
      step();
      apply_stimulus(1'b0, 14'h0, 9'h0);
      check_output("idle_ack", 32'(wr_ack), 32'd1);
      check_output("idle_wren0", 32'(mem_wren), 32'd0);
      step();
      check_output("idle_ack_pulse", 32'(wr_ack), 32'd0);
      check_output("idle_wren1", 32'(mem_wren), 32'd0);
      step();
      check_output("idle_wr_en", 32'(mem_wren), 32'd1);
      check_output("idle_wr_addr", 32'(mem_address), 32'h0042);
      check_output("idle_wr_data", 32'(mem_data), 32'h1FF);
      step();
      check_output("idle_wr_end", 32'(mem_wren), 32'd0);
      check_output("idle_back_addr", 32'(mem_address), 32'h1234);

      // Blocked writes fill the FIFO
      $display("[TB] blocked writes");
      print_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 14'(14'h10 + i), 9'(9'h100 + i));
         step();
         check_output("blk_ack", 32'(wr_ack), 32'd1);
         check_output("blk_wren", 32'(mem_wren), 32'd0);
      end
      check_output("blk_full", 32'(fifo_full), 32'd1);
      apply_stimulus(1'b1, 14'h0014, 9'h114);
      step();
      check_output("blk_5th_ack", 32'(wr_ack), 32'd0);
      step();
      check_output("blk_5th_ack_b", 32'(wr_ack), 32'd0);
      check_output("blk_5th_wren", 32'(mem_wren), 32'd0);
      check_output("blk_5th_full", 32'(fifo_full), 32'd1);
      apply_stimulus(1'b0, 14'h0, 9'h0);
      print_busy = 1'b0;
      step();
      check_output("blk_enter_drain", 32'(mem_wren), 32'd0);
      for (int i = 0; i < 4; i++) begin
         step();
         check_output("blk_drain_wren", 32'(mem_wren), 32'd1);
         check_output("blk_drain_addr", 32'(mem_address), 32'h10 + 32'(i));
         check_output("blk_drain_data", 32'(mem_data), 32'h100 + 32'(i));
      end
      step();
      check_output("blk_done_wren", 32'(mem_wren), 32'd0);
      check_output("blk_done_addr", 32'(mem_address), 32'h1234);
      check_output("blk_done_full", 32'(fifo_full), 32'd0);

      // Drain interrupted by the print path
      $display("[TB] interrupted drain");
      print_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         apply_stimulus(1'b1, 14'(14'h20 + i), 9'(9'h120 + i));
         step();
      end
      apply_stimulus(1'b0, 14'h0, 9'h0);
      print_busy = 1'b0;
      step();
      step();
      check_output("int_first_wren", 32'(mem_wren), 32'd1);
      check_output("int_first_addr", 32'(mem_address), 32'h20);
      print_busy    = 1'b1;
      print_address = 14'h0ABC;
      step();
      check_output("int_stop_wren", 32'(mem_wren), 32'd0);
      check_output("int_stop_addr", 32'(mem_address), 32'h0ABC);
      step();
      check_output("int_hold_wren", 32'(mem_wren), 32'd0);
      print_busy = 1'b0;
      step();
      step();
      check_output("int_rest0_wren", 32'(mem_wren), 32'd1);
      check_output("int_rest0_addr", 32'(mem_address), 32'h21);
      step();
      check_output("int_rest1_addr", 32'(mem_address), 32'h22);
      check_output("int_rest1_data", 32'(mem_data), 32'h122);
      step();
      check_output("int_done_wren", 32'(mem_wren), 32'd0);

      // Push and pop together while full
      $display("[TB] full push and pop");
      print_busy = 1'b1;
      for (int i = 0; i < 4; i++) begin
         apply_stimulus(1'b1, 14'(14'h30 + i), 9'(9'h130 + i));
         step();
      end
      apply_stimulus(1'b0, 14'h0, 9'h0);
      check_output("fp_full", 32'(fifo_full), 32'd1);
      print_busy = 1'b0;
      step();
      apply_stimulus(1'b1, 14'h0034, 9'h134);
      step();
      apply_stimulus(1'b0, 14'h0, 9'h0);
      check_output("fp_ack", 32'(wr_ack), 32'd1);
      check_output("fp_wren", 32'(mem_wren), 32'd1);
      check_output("fp_addr", 32'(mem_address), 32'h30);
      check_output("fp_still_full", 32'(fifo_full), 32'd1);
      for (int i = 1; i < 5; i++) begin
         step();
         check_output("fp_drain_wren", 32'(mem_wren), 32'd1);
         check_output("fp_drain_addr", 32'(mem_address), 32'h30 + 32'(i));
         check_output("fp_drain_data", 32'(mem_data), 32'h130 + 32'(i));
      end
      step();
      check_output("fp_done_wren", 32'(mem_wren), 32'd0);
      check_output("fp_done_full", 32'(fifo_full), 32'd0);
      check_output("fp_no_stall", 32'(print_stall), 32'd0);

`ifdef SPRITE_ARB_STARVE_EN
      // Forced write after starve_limit blocked pixel ticks
      $display("[TB] starvation");
      print_busy = 1'b1;
      apply_stimulus(1'b1, 14'h0050, 9'h150);
      step();
      apply_stimulus(1'b0, 14'h0, 9'h0);
      for (int k = 1; k <= 4; k++) begin
         pixel_tick = 1'b1;
         step();
         pixel_tick = 1'b0;
         check_output("stv_wait_wren", 32'(mem_wren), 32'd0);
         if (k < 4) step();
      end
      step();
      check_output("stv_force_wren", 32'(mem_wren), 32'd1);
      check_output("stv_force_stall", 32'(print_stall), 32'd1);
      check_output("stv_force_addr", 32'(mem_address), 32'h50);
      check_output("stv_force_data", 32'(mem_data), 32'h150);
      step();
      check_output("stv_after_wren", 32'(mem_wren), 32'd0);
      check_output("stv_after_stall", 32'(print_stall), 32'd0);
      print_busy = 1'b0;
      step();
      step();
      check_output("stv_empty_wren", 32'(mem_wren), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
